// File: rtl/reg_file_scb.sv
// Dual-write, dual-read register file with a per-register busy scoreboard for instruction issue.
// Optional macro RF_BYPASS_EN forwards same-cycle write data and busy clear to the read ports.
module reg_file_scb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wa;
    logic              wb;
    logic              ia;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Qualified write/issue strobes: dropped in reset and for a hardwired r0.
    always_comb begin
        wa = wr_en_a && !rst && !is_zero(wr_addr_a);
        wb = wr_en_b && !rst && !is_zero(wr_addr_b);
        ia = iss_en  && !rst && !is_zero(iss_addr);
    end

    // Writes clear busy, issue sets it afterwards so issue wins on a same-address collision.
    always_comb begin
        busy_nxt = busy;
        if (wa) busy_nxt[wr_addr_a] = 1'b0;
        if (wb) busy_nxt[wr_addr_b] = 1'b0;
        if (ia) busy_nxt[iss_addr]  = 1'b1;
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wa) regs[wr_addr_a] <= wr_data_a;
            if (wb) regs[wr_addr_b] <= wr_data_b;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_busy1 = busy[rd_addr1];
`ifdef RF_BYPASS_EN
        if (wb && (wr_addr_b == rd_addr1)) begin
            rd_data1 = wr_data_b;
            rd_busy1 = ia && (iss_addr == rd_addr1);
        end else if (wa && (wr_addr_a == rd_addr1)) begin
            rd_data1 = wr_data_a;
            rd_busy1 = ia && (iss_addr == rd_addr1);
        end
`endif
        if (is_zero(rd_addr1)) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        rd_busy2 = busy[rd_addr2];
`ifdef RF_BYPASS_EN
        if (wb && (wr_addr_b == rd_addr2)) begin
            rd_data2 = wr_data_b;
            rd_busy2 = ia && (iss_addr == rd_addr2);
        end else if (wa && (wr_addr_a == rd_addr2)) begin
            rd_data2 = wr_data_a;
            rd_busy2 = ia && (iss_addr == rd_addr2);
        end
`endif
        if (is_zero(rd_addr2)) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_scb.sv
// Scoreboard bench for reg_file_scb: default 32x32 instance with r0 hardwired, plus a 16-bit x 8 instance
// with ZERO_REG=0 for the small-parameter sweep.
module tb_reg_file_scb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en_a = 1'b0, wr_en_b = 1'b0, iss_en = 1'b0;
    logic [4:0]  wr_addr_a = '0, wr_addr_b = '0, iss_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [31:0] wr_data_a = '0, wr_data_b = '0;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic [5:0]  busy_cnt;

    logic        s_wr_en_a = 1'b0, s_wr_en_b = 1'b0, s_iss_en = 1'b0;
    logic [2:0]  s_wr_addr_a = '0, s_wr_addr_b = '0, s_iss_addr = '0, s_rd_addr1 = '0, s_rd_addr2 = '0;
    logic [15:0] s_wr_data_a = '0, s_wr_data_b = '0;
    logic [15:0] s_rd_data1, s_rd_data2;
    logic        s_rd_busy1, s_rd_busy2;
    logic [3:0]  s_busy_cnt;

    always #5 clk = ~clk;

    reg_file_scb dut (
        .clk(clk), .rst(rst),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    reg_file_scb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_s (
        .clk(clk), .rst(rst),
        .wr_en_a(s_wr_en_a), .wr_addr_a(s_wr_addr_a), .wr_data_a(s_wr_data_a),
        .wr_en_b(s_wr_en_b), .wr_addr_b(s_wr_addr_b), .wr_data_b(s_wr_data_b),
        .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
        .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
        .rd_busy1(s_rd_busy1), .rd_busy2(s_rd_busy2),
        .iss_en(s_iss_en), .iss_addr(s_iss_addr), .busy_cnt(s_busy_cnt)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pop every pending expectation and compare it with the selected DUT output as seen now.
    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       act = rd_data1;
                1:       act = 32'(rd_busy1);
                2:       act = 32'(busy_cnt);
                3:       act = rd_data2;
                4:       act = 32'(rd_busy2);
                5:       act = 32'(s_busy_cnt);
                6:       act = 32'(s_rd_data1);
                default: act = 32'(s_rd_busy1);
            endcase
            check(e.tag, act, e.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_busy = '0;
    endtask

    // Reference behaviour of the default instance for the edge about to happen.
    task automatic model_edge();
        if (!rst) begin
            if (wr_en_a && wr_addr_a != 0) begin
                m_reg[wr_addr_a]  = wr_data_a;
                m_busy[wr_addr_a] = 1'b0;
            end
            if (wr_en_b && wr_addr_b != 0) begin
                m_reg[wr_addr_b]  = wr_data_b;
                m_busy[wr_addr_b] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        wr_en_a = 1'b0; wr_en_b = 1'b0; iss_en = 1'b0;
        s_wr_en_a = 1'b0; s_wr_en_b = 1'b0; s_iss_en = 1'b0;
        #1;
        drain();
    endtask

    task automatic step();
        model_edge();
        clk_step();
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
        wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_en = 1'b1; iss_addr = a;
    endtask

    initial begin
        model_reset();
        #2;
        rd_addr1 = 5'd5;
        push_exp("reset_rd_data", 0, 32'h0);
        push_exp("reset_busy_cnt", 2, 32'h0);
        push_exp("reset_s_busy_cnt", 5, 32'h0);
        drain();
        #11 rst = 1'b0;
        @(negedge clk);

        // Dual-write collision: port B wins.
        wr_a(5'd7, 32'h1111_1111); wr_b(5'd7, 32'h2222_2222); rd_addr1 = 5'd7;
        push_exp("collision_b_wins", 0, 32'h2222_2222);
        step();

        // Asynchronous reset mid-cycle discards data and busy state.
        wr_a(5'd5, 32'hDEAD_BEEF); iss(5'd6); rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        push_exp("pre_reset_data", 0, 32'hDEAD_BEEF);
        push_exp("pre_reset_busy", 4, 32'h1);
        push_exp("pre_reset_cnt", 2, 32'h1);
        step();
        #3 rst = 1'b1;
        model_reset();
        #1;
        push_exp("async_rst_data", 0, 32'h0);
        push_exp("async_rst_busy", 4, 32'h0);
        push_exp("async_rst_cnt", 2, 32'h0);
        drain();
        rd_addr2 = 5'd7;
        wr_a(5'd5, 32'h0000_0001); iss(5'd5);
        push_exp("rst_ignores_write", 0, 32'h0);
        push_exp("rst_clears_r7", 3, 32'h0);
        push_exp("rst_ignores_issue", 2, 32'h0);
        step();
        #3 rst = 1'b0;

        // Scoreboard sequence.
        iss(5'd3); push_exp("iss_r3_cnt", 2, 32'd1); step();
        iss(5'd4); push_exp("iss_r4_cnt", 2, 32'd2); step();
        iss(5'd5); push_exp("iss_r5_cnt", 2, 32'd3); step();
        wr_a(5'd4, 32'hAAAA_0004); rd_addr1 = 5'd4;
        push_exp("wr_clears_busy", 1, 32'h0);
        push_exp("wr_clears_cnt", 2, 32'd2);
        push_exp("wr_busy_data", 0, 32'hAAAA_0004);
        step();
        iss(5'd3); wr_b(5'd3, 32'h3333_3333); rd_addr1 = 5'd3;
        push_exp("iss_wr_busy_set", 1, 32'h1);
        push_exp("iss_wr_data", 0, 32'h3333_3333);
        push_exp("iss_wr_cnt", 2, 32'd2);
        step();
        iss(5'd5); push_exp("reissue_no_count", 2, 32'd2); step();
        wr_b(5'd5, 32'h5555_0005); rd_addr2 = 5'd5;
        push_exp("wr_b_clears_busy", 4, 32'h0);
        push_exp("wr_b_clears_cnt", 2, 32'd1);
        step();

        // Hardwired zero register.
        wr_a(5'd0, 32'hFFFF_FFFF); wr_b(5'd0, 32'hFFFF_FFFF); iss(5'd0); rd_addr1 = 5'd0;
        push_exp("zero_rd_data", 0, 32'h0);
        push_exp("zero_rd_busy", 1, 32'h0);
        push_exp("zero_cnt", 2, 32'd1);
        step();

        // Same-cycle read of a write being performed.
        rd_addr1 = 5'd9;
        wr_a(5'd9, 32'h1234_5678);
        #1;
`ifdef RF_BYPASS_EN
        push_exp("bypass_same_cycle", 0, 32'h1234_5678);
`else
        push_exp("no_bypass_old", 0, 32'h0);
`endif
        drain();
        push_exp("write_next_cycle", 0, 32'h1234_5678);
        step();
        iss(5'd10); step();
        wr_b(5'd10, 32'h0000_5555); rd_addr2 = 5'd10;
        #1;
`ifdef RF_BYPASS_EN
        push_exp("bypass_busy_clear", 4, 32'h0);
        push_exp("bypass_data_b", 3, 32'h0000_5555);
`else
        push_exp("stored_busy", 4, 32'h1);
        push_exp("stored_data", 3, 32'h0);
`endif
        drain();
        push_exp("r10_after_busy", 4, 32'h0);
        push_exp("r10_after_data", 3, 32'h0000_5555);
        step();
        wr_a(5'd12, 32'hAAAA_AAAA); wr_b(5'd12, 32'hBBBB_BBBB); iss(5'd12);
        rd_addr1 = 5'd12; rd_addr2 = 5'd0;
        #1;
`ifdef RF_BYPASS_EN
        push_exp("bypass_b_over_a", 0, 32'hBBBB_BBBB);
        push_exp("bypass_issue_busy", 1, 32'h1);
`else
        push_exp("no_bypass_r12", 0, 32'h0);
        push_exp("no_bypass_busy", 1, 32'h0);
`endif
        push_exp("bypass_zero_mask", 3, 32'h0);
        drain();
        wr_a(5'd0, 32'hCAFE_F00D);
        #1;
        push_exp("zero_mask_wr0", 3, 32'h0);
        drain();
        step();

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            wr_en_a   = 1'($urandom_range(0, 1));
            wr_addr_a = 5'($urandom_range(0, 7));
            wr_data_a = $urandom;
            wr_en_b   = 1'($urandom_range(0, 1));
            wr_addr_b = 5'($urandom_range(0, 7));
            wr_data_b = $urandom;
            iss_en    = 1'($urandom_range(0, 1));
            iss_addr  = 5'($urandom_range(0, 7));
            rd_addr1  = 5'($urandom_range(0, 7));
            rd_addr2  = 5'($urandom_range(0, 31));
            model_edge();
            push_exp("rand_rd_data1", 0, m_reg[rd_addr1]);
            push_exp("rand_rd_busy1", 1, 32'(m_busy[rd_addr1]));
            push_exp("rand_rd_data2", 3, m_reg[rd_addr2]);
            push_exp("rand_busy_cnt", 2, 32'($countones(m_busy)));
            clk_step();
        end

        // Small instance: fill all 8 registers including r0, then issue all.
        for (int a = 0; a < 8; a++) begin
            s_wr_en_a = 1'b1; s_wr_addr_a = 3'(a); s_wr_data_a = 16'(16'hA0 + a);
            step();
        end
        for (int a = 0; a < 8; a++) begin
            s_iss_en = 1'b1; s_iss_addr = 3'(a);
            push_exp("sweep_cnt", 5, 32'(a + 1));
            step();
        end
        s_iss_en = 1'b1; s_iss_addr = 3'd0;
        push_exp("sweep_no_wrap", 5, 32'd8);
        step();
        for (int a = 0; a < 8; a++) begin
            s_rd_addr1 = 3'(a);
            #1;
            push_exp("sweep_data", 6, 32'(16'hA0 + a));
            push_exp("sweep_busy", 7, 32'h1);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
